// File: rtl/sreg_pq.sv
// Sorted shift-register min-priority queue: head (smallest key) at r_ent[0].
// Insertions take one extra INS cycle; equal keys keep arrival order.
module sreg_pq #(
  parameter int DEPTH = 8,
  parameter int KV_W  = 16,
  parameter int KEY_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  logic            deq,
  input  logic [KV_W-1:0] kvi,
  output logic [KV_W-1:0] kvo,
  output logic            full,
  output logic            empty,
  output logic            busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_INS = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KV_W-1:0]  r_ent [DEPTH];
  logic [KV_W-1:0]  w_ent_nxt [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [KV_W-1:0]  r_pend;
  logic [KV_W-1:0]  w_pend_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_busy;
  logic             w_rem;
  logic             w_ins;
  logic             w_found;
  logic [CNT_W-1:0] w_pos;

  // Insert position: first valid entry whose key is strictly greater than the pending key
  always_comb begin
    w_found = 1'b0;
    w_pos   = r_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && (CNT_W'(i) < r_cnt) &&
          (r_ent[i][KV_W-1 -: KEY_W] > r_pend[KV_W-1 -: KEY_W])) begin
        w_found = 1'b1;
        w_pos   = CNT_W'(i);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic for the FSM, storage array, count and pending word
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ent_nxt   = r_ent;
    w_rem       = deq && (r_cnt != CNT_W'(0));
    w_ins       = enq && (w_rem || (r_cnt != CNT_W'(DEPTH)));
    case (r_state)
      ST_IDLE: begin
        if (w_rem) begin
          // Slots at and beyond cnt stay zero so r_ent[0] doubles as kvo
          for (int i = 0; i < DEPTH - 1; i++) begin
            w_ent_nxt[i] = r_ent[i+1];
          end
          w_ent_nxt[DEPTH-1] = {KV_W{1'b0}};
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
        if (w_ins) begin
          w_pend_nxt  = kvi;
          w_state_nxt = ST_INS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INS: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == w_pos) begin
            w_ent_nxt[i] = r_pend;
          end else if ((i > 0) && (CNT_W'(i) > w_pos)) begin
            w_ent_nxt[i] = r_ent[(i > 0) ? i - 1 : 0];
          end else begin
            w_ent_nxt[i] = r_ent[i];
          end
        end
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_busy  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == CNT_W'(0));
      r_busy  <= (w_state_nxt == ST_INS);
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_ent_nxt[i];
      end
    end
  end

  assign kvo   = r_ent[0];
  assign full  = r_full;
  assign empty = r_empty;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sreg_pq.sv
// Directed self-checking bench for sreg_pq: inputs driven and outputs sampled on negedge.
module tb_sreg_pq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq = 1'b0;
  logic        deq = 1'b0;
  logic [15:0] kvi = 16'h0000;
  logic [15:0] kvo;
  logic        full;
  logic        empty;
  logic        busy;

  int chk_n = 0;
  int err_n = 0;

  sreg_pq #(.DEPTH(8), .KV_W(16), .KEY_W(8)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(kvo), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, cross one rising edge, release to idle at the next negedge
  task automatic cyc(input logic e, input logic d, input logic [15:0] k);
    enq = e;
    deq = d;
    kvi = k;
    @(negedge clk);
    enq = 1'b0;
    deq = 1'b0;
    kvi = 16'h0000;
  endtask

  task automatic push(input logic [15:0] k);
    cyc(1'b1, 1'b0, k);
    cyc(1'b0, 1'b0, 16'h0000);
  endtask

  logic [15:0] drain_exp [8];

  initial begin
    drain_exp[0] = 16'h0300; drain_exp[1] = 16'h0400;
    drain_exp[2] = 16'h0500; drain_exp[3] = 16'h0577;
    drain_exp[4] = 16'h0600; drain_exp[5] = 16'h0700;
    drain_exp[6] = 16'h0800; drain_exp[7] = 16'h0000;

    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    check("rst_kvo", kvo, 16'h0000);
    check("rst_empty", {15'd0, empty}, 16'd1);
    check("rst_full", {15'd0, full}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);

    cyc(1'b0, 1'b1, 16'h0000);
    check("deq_empty_empty", {15'd0, empty}, 16'd1);
    check("deq_empty_kvo", kvo, 16'h0000);

    cyc(1'b1, 1'b0, 16'h5001);
    check("enq1_busy", {15'd0, busy}, 16'd1);
    cyc(1'b0, 1'b0, 16'h0000);
    check("enq1_busy_done", {15'd0, busy}, 16'd0);
    check("enq1_kvo", kvo, 16'h5001);
    check("enq1_empty", {15'd0, empty}, 16'd0);
    push(16'h2002);
    check("enq2_kvo", kvo, 16'h2002);
    push(16'h8003);
    check("enq3_kvo", kvo, 16'h2002);
    cyc(1'b0, 1'b1, 16'h0000);
    check("deq1_kvo", kvo, 16'h5001);
    cyc(1'b0, 1'b1, 16'h0000);
    check("deq2_kvo", kvo, 16'h8003);
    cyc(1'b0, 1'b1, 16'h0000);
    check("deq3_kvo", kvo, 16'h0000);
    check("deq3_empty", {15'd0, empty}, 16'd1);

    push(16'h30AA);
    push(16'h30BB);
    check("tie_head", kvo, 16'h30AA);
    cyc(1'b0, 1'b1, 16'h0000);
    check("tie_second", kvo, 16'h30BB);
    cyc(1'b0, 1'b1, 16'h0000);
    check("tie_empty", {15'd0, empty}, 16'd1);

    for (int k = 8; k >= 1; k--) begin
      push({k[7:0], 8'h00});
    end
    check("fill_full", {15'd0, full}, 16'd1);
    check("fill_kvo", kvo, 16'h0100);
    cyc(1'b1, 1'b0, 16'h0099);
    check("over_busy", {15'd0, busy}, 16'd0);
    check("over_kvo", kvo, 16'h0100);
    check("over_full", {15'd0, full}, 16'd1);

    cyc(1'b1, 1'b1, 16'h0577);
    check("repl_busy", {15'd0, busy}, 16'd1);
    check("repl_ins_kvo", kvo, 16'h0200);
    check("repl_ins_full", {15'd0, full}, 16'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    check("repl_busy_done", {15'd0, busy}, 16'd0);
    check("repl_kvo", kvo, 16'h0200);
    check("repl_full", {15'd0, full}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 16'h0000);
      check($sformatf("drain%0d", i), kvo, drain_exp[i]);
    end
    check("drain_empty", {15'd0, empty}, 16'd1);

    cyc(1'b1, 1'b0, 16'h1234);
    check("abort_busy_pre", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    check("abort_kvo", kvo, 16'h0000);
    check("abort_empty", {15'd0, empty}, 16'd1);
    check("abort_busy", {15'd0, busy}, 16'd0);

    cyc(1'b1, 1'b0, 16'h00A1);
    cyc(1'b1, 1'b0, 16'h00B2);
    check("drop_busy", {15'd0, busy}, 16'd0);
    check("drop_kvo", kvo, 16'h00A1);
    cyc(1'b0, 1'b1, 16'h0000);
    check("drop_empty", {15'd0, empty}, 16'd1);
    check("drop_kvo_after", kvo, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", chk_n, err_n);
    $finish;
  end

endmodule

// File: doc/sreg_pq.md
Name: sreg_pq

Overview:
- Shift-register (sorted register array) priority queue. Device-side responder of the pq_if protocol: consumes enq/deq/kvi from a client and reports kvo/full/empty/busy.
- Drop-in alternative to heap_pq for the HWPQ study. It is instantiated behind pq_if.dev, or directly by the board wrappers (pushbutton or single-pulse driven).
- Min-queue: the smallest key is always at the head.

Parameters:
- DEPTH, 8, number of entries (>=2).
- KV_W, 16, width of one key/value word; matches kv_t.
- KEY_W, 8, key field = kv[KV_W-1 -: KEY_W] (MSBs); remaining LSBs are the value, carried unchanged.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enq  in  1  enqueue request, sampled each clk edge.
- deq  in  1  dequeue request; enq & deq in the same cycle = replace.
- kvi  in  KV_W  key/value to enqueue, sampled with enq.
- kvo  out  KV_W  current head entry (smallest key); 0 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  insert in progress; requests are ignored while high.

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the clk rising edge.
- Storage: ent[0..DEPTH-1], count cnt (0..DEPTH). ent[0..cnt-1] are valid and sorted ascending by key.
- Ties: a new entry goes after all existing entries with an equal key (FIFO among equals).
- Reset: cnt=0, all ent=0, pend=0, state=IDLE, kvo=0, empty=1, full=0, busy=0. Reset asserted mid-insert aborts the insert; nothing is written.
- All outputs are registered and reflect state after the last completed edge.
- FSM states:
  - IDLE: busy=0, requests accepted.
  - INS: busy=1, 1 cycle.
- IDLE, deq only, !empty: shift ent[i]<=ent[i+1], cnt-1. Complete in 1 cycle; the new head appears on kvo the next cycle. Stay in IDLE.
- IDLE, enq only, !full: pend<=kvi, go to INS.
- IDLE, enq & deq, !empty: remove the head as for deq, pend<=kvi, go to INS. Allowed when full.
- IDLE, enq & deq, empty: treated as enq only.
- IDLE, enq only, full: ignored; no state change.
- IDLE, deq only, empty: ignored; no state change.
- INS:
  - gt[i] = (i<cnt) && key(ent[i]) > key(pend), computed combinationally against the stored array.
  - Position p = first i with gt[i]; p = cnt if there is none.
  - ent[i+1]<=ent[i] for i>=p; ent[p]<=pend; cnt+1; return to IDLE.
- enq/deq sampled while busy=1 are dropped; clients must hold off.
- Latency (request edge t):
  - deq: kvo/empty/full updated at t+1.
  - enq/replace: busy=1 during t+1..t+2; kvo/empty/full final at t+2. Back-to-back enq is possible every 2 cycles.
- kvo during INS after a replace shows the post-removal head (0 if the queue is now empty).
- full/empty are derived from the registered cnt only; never both high.
- No arithmetic on keys beyond unsigned compare; the value field is never compared.

Test Plan:
- Reset → kvo=16'h0000, empty=1, full=0, busy=0. Single deq pulse on empty → no change, empty stays 1.
- Enq 16'h5001, 16'h2002, 16'h8003 (2-cycle spacing) → kvo=16'h2002 after the 2nd insert. Three deqs → kvo sequence 16'h5001, 16'h8003, 16'h0000, empty=1.
- Ties: enq 16'h30AA, then 16'h30BB → deq order 16'h30AA then 16'h30BB.
- Fill DEPTH=8 entries with keys 8..1 → full=1, kvo key=1. Extra enq 16'h0099 → ignored, cnt stays 8, kvo unchanged.
- Full, replace with kvi=16'h0577 → busy high one cycle. kvo becomes 16'h0200-keyed entry during INS, then final kvo key=2, full=1. Drained order contains 0x05 in sorted position.
- Enq accepted, rst asserted in the INS cycle → after the edge cnt=0, kvo=0, empty=1, busy=0. Enq sampled while busy=1 → dropped, cnt unaffected.
